// File: rtl/i4002_vfd_pkg.sv
// Shared definitions for the i4002 Working Register VFD scanner.
// Contents: scanner FSM state encoding, the status-character address, the serial word width
// and the hex-to-7-segment table (bit order {g,f,e,d,c,b,a}).
package i4002_vfd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetchStatus,
        StFetchDigit,
        StShift,
        StLatch,
        StDwell
    } vfd_state_e;

    // Status character 16 of the Working Register holds the decimal-point position.
    localparam logic [4:0] WR_STATUS_ADDR = 5'd16;

    // 16 grid bits, decimal point, 7 segments.
    localparam int unsigned SHIFT_WIDTH = 24;

    // Entry i is the segment pattern for hex digit i.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/i4002_vfd_segdecode.sv
// Combinational nibble to 7-segment map, shared with other display blocks.
// Ports:
//   nibble  in  4  hex value 0..F
//   seg     out 7  segments {g,f,e,d,c,b,a}, 1 = lit
module i4002_vfd_segdecode
    import i4002_vfd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/i4002_vfd_scanner.sv
// Scans the i4002 Working Register (RAM0 register 1) onto a serial-input VFD driver.
// Each digit is fetched, decoded, shifted out MSB first as a 24-bit grid/dp/segment word,
// latched, then left unblanked for DWELL_CYCLES. The status character (address 16) gives
// the decimal-point position and is re-read at the start of every frame.
// Ports:
//   sysclk      in   1  system clock
//   sysreset_n  in   1  asynchronous active-low reset
//   enable      in   1  scan enable (level); a started digit always completes its dwell
//   ram_addr    out  5  registered address to the RAM second read port
//   ram_data    in   4  RAM read data, combinational from ram_addr
//   vfd_sclk    out  1  driver serial clock
//   vfd_sdata   out  1  driver serial data, MSB first
//   vfd_latch   out  1  driver latch strobe, one cycle
//   vfd_blank   out  1  driver blanking, 1 = all off
//   busy        out  1  high outside IDLE
//   frame_done  out  1  one-cycle pulse after the last digit's dwell
module i4002_vfd_scanner
    import i4002_vfd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 16,
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned DWELL_CYCLES = 1024
) (
    input  logic       sysclk,
    input  logic       sysreset_n,
    input  logic       enable,
    output logic [4:0] ram_addr,
    input  logic [3:0] ram_data,
    output logic       vfd_sclk,
    output logic       vfd_sdata,
    output logic       vfd_latch,
    output logic       vfd_blank,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [3:0]         LAST_DIGIT = 4'(NUM_DIGITS - 1);
    localparam logic [4:0]         TOP_BIT    = 5'(SHIFT_WIDTH - 1);

    vfd_state_e state_q, state_d;

    logic [3:0]             digit_q, digit_d;
    logic [3:0]             dp_pos_q, dp_pos_d;
    logic [4:0]             ram_addr_q, ram_addr_d;
    logic [SHIFT_WIDTH-1:0] word_q, word_d;
    logic [4:0]             bit_q, bit_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DWELL_W-1:0]     dwell_q, dwell_d;
    logic                   sclk_q, sclk_d;
    logic                   sdata_q, sdata_d;
    logic                   frame_done_q, frame_done_d;

    logic [6:0]             seg;
    logic [SHIFT_WIDTH-1:0] word_load;
    logic                   div_end, dwell_end, shift_end, last_digit;

    i4002_vfd_segdecode u_segdecode (
        .nibble (ram_data),
        .seg    (seg)
    );

    assign word_load  = {16'h0001 << digit_q, digit_q == dp_pos_q, seg};
    assign div_end    = (div_q == DIV_LAST);
    assign dwell_end  = (dwell_q == DWELL_LAST);
    // Shift ends at the close of bit 0's high phase.
    assign shift_end  = div_end && sclk_q && (bit_q == 5'd0);
    assign last_digit = (digit_q == LAST_DIGIT);

    // State register
    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable is only consulted in IDLE and at the end of a dwell.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:        if (enable) state_d = StFetchStatus;
            StFetchStatus: state_d = StFetchDigit;
            StFetchDigit:  state_d = StShift;
            StShift:       if (shift_end) state_d = StLatch;
            StLatch:       state_d = StDwell;
            StDwell: begin
                if (dwell_end) begin
                    if (!enable)         state_d = StIdle;
                    else if (last_digit) state_d = StFetchStatus;
                    else                 state_d = StFetchDigit;
                end
            end
            default:       state_d = StIdle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (state_q != StIdle);
        vfd_latch = (state_q == StLatch);
        vfd_blank = (state_q != StDwell);
    end

    // Datapath next-state
    always_comb begin
        digit_d      = digit_q;
        dp_pos_d     = dp_pos_q;
        ram_addr_d   = ram_addr_q;
        word_d       = word_q;
        bit_d        = bit_q;
        div_d        = div_q;
        dwell_d      = dwell_q;
        sclk_d       = sclk_q;
        sdata_d      = sdata_q;
        frame_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable) begin
                    ram_addr_d = WR_STATUS_ADDR;
                    digit_d    = 4'd0;
                end
            end
            StFetchStatus: begin
                dp_pos_d   = ram_data;
                ram_addr_d = {1'b0, digit_q};
            end
            StFetchDigit: begin
                word_d  = word_load;
                bit_d   = TOP_BIT;
                div_d   = '0;
                sclk_d  = 1'b0;
                sdata_d = word_load[SHIFT_WIDTH-1];
            end
            StShift: begin
                if (div_end) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Data moves only together with the falling sclk edge.
                        sclk_d = 1'b0;
                        if (bit_q != 5'd0) begin
                            bit_d   = bit_q - 5'd1;
                            sdata_d = word_q[bit_q - 5'd1];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StLatch: begin
                dwell_d = '0;
            end
            StDwell: begin
                if (dwell_end) begin
                    if (last_digit) begin
                        digit_d      = 4'd0;
                        frame_done_d = 1'b1;
                        if (enable) ram_addr_d = WR_STATUS_ADDR;
                    end else begin
                        digit_d = digit_q + 4'd1;
                        if (enable) ram_addr_d = {1'b0, digit_q + 4'd1};
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            digit_q      <= 4'd0;
            dp_pos_q     <= 4'd0;
            ram_addr_q   <= 5'd0;
            word_q       <= '0;
            bit_q        <= 5'd0;
            div_q        <= '0;
            dwell_q      <= '0;
            sclk_q       <= 1'b0;
            sdata_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            digit_q      <= digit_d;
            dp_pos_q     <= dp_pos_d;
            ram_addr_q   <= ram_addr_d;
            word_q       <= word_d;
            bit_q        <= bit_d;
            div_q        <= div_d;
            dwell_q      <= dwell_d;
            sclk_q       <= sclk_d;
            sdata_q      <= sdata_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign vfd_sclk   = sclk_q;
    assign vfd_sdata  = sdata_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_i4002_vfd_scanner.sv
// Directed bench for i4002_vfd_scanner: one instance at CLK_DIV=1 for frame content and
// control behaviour, one at CLK_DIV=3 for serial timing. Both read a shared RAM model.
module tb_i4002_vfd_scanner;

    logic sysclk     = 1'b0;
    logic sysreset_n = 1'b0;
    logic enable     = 1'b0;
    logic en3        = 1'b0;

    always #5 sysclk = ~sysclk;

    logic [3:0] ram [0:31];

    // CLK_DIV=1 instance
    logic [4:0] ram_addr;
    logic [3:0] ram_data;
    logic       vfd_sclk, vfd_sdata, vfd_latch, vfd_blank, busy, frame_done;
    // CLK_DIV=3 instance
    logic [4:0] ram_addr3;
    logic [3:0] ram_data3;
    logic       vfd_sclk3, vfd_sdata3, vfd_latch3, vfd_blank3, busy3, frame_done3;

    assign ram_data  = ram[ram_addr];
    assign ram_data3 = ram[ram_addr3];

    i4002_vfd_scanner #(.NUM_DIGITS(16), .CLK_DIV(1), .DWELL_CYCLES(4)) dut (
        .sysclk     (sysclk),
        .sysreset_n (sysreset_n),
        .enable     (enable),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .vfd_sclk   (vfd_sclk),
        .vfd_sdata  (vfd_sdata),
        .vfd_latch  (vfd_latch),
        .vfd_blank  (vfd_blank),
        .busy       (busy),
        .frame_done (frame_done)
    );

    i4002_vfd_scanner #(.NUM_DIGITS(16), .CLK_DIV(3), .DWELL_CYCLES(4)) dut3 (
        .sysclk     (sysclk),
        .sysreset_n (sysreset_n),
        .enable     (en3),
        .ram_addr   (ram_addr3),
        .ram_data   (ram_data3),
        .vfd_sclk   (vfd_sclk3),
        .vfd_sdata  (vfd_sdata3),
        .vfd_latch  (vfd_latch3),
        .vfd_blank  (vfd_blank3),
        .busy       (busy3),
        .frame_done (frame_done3)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Capture of shifted words from the CLK_DIV=1 instance.
    logic        sclk1_prev = 1'b0;
    logic [23:0] shreg1     = '0;
    logic [23:0] words [0:127];
    int          nlat1  = 0;
    int          fd_cnt = 0;
    int          fd_cyc [0:3];

    always @(negedge sysclk) begin
        if (vfd_sclk && !sclk1_prev) shreg1 <= {shreg1[22:0], vfd_sdata};
        sclk1_prev <= vfd_sclk;
        if (vfd_latch) begin
            words[7'(nlat1)] <= shreg1;
            nlat1 <= nlat1 + 1;
        end
        if (frame_done) begin
            fd_cyc[2'(fd_cnt)] <= cyc;
            fd_cnt <= fd_cnt + 1;
        end
    end

    // Serial timing observation on the CLK_DIV=3 instance.
    logic        sclk3_prev  = 1'b0;
    logic        sdata3_prev = 1'b0;
    logic [23:0] shreg3      = '0;
    logic [23:0] word3       = '0;
    int          run3 = 0, rises3 = 0, lat3 = 0;
    int          high_bad = 0, low_bad = 0, sdata_bad = 0, rise_bad = 0;
    int          lat_cyc3 [0:3];

    always @(negedge sysclk) begin
        if (vfd_sclk3 != sclk3_prev) begin
            run3 <= 1;
            if (sclk3_prev) begin
                if (run3 != 3) high_bad <= high_bad + 1;
            end else begin
                if (rises3 != 0 && run3 != 3) low_bad <= low_bad + 1;
                rises3 <= rises3 + 1;
                shreg3 <= {shreg3[22:0], vfd_sdata3};
            end
        end else begin
            run3 <= run3 + 1;
        end
        if (vfd_sdata3 !== sdata3_prev && vfd_sclk3) sdata_bad <= sdata_bad + 1;
        sclk3_prev  <= vfd_sclk3;
        sdata3_prev <= vfd_sdata3;
        if (vfd_latch3) begin
            if (rises3 != 24) rise_bad <= rise_bad + 1;
            rises3 <= 0;
            if (lat3 == 0) word3 <= shreg3;
            lat_cyc3[2'(lat3)] <= cyc;
            lat3 <= lat3 + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sysclk);
        #1;
    endtask

    int idle_bad;
    int base;
    int c0;

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 4'(i);
        ram[16] = 4'd3;
        ram[7]  = 4'd2;

        // Reset values and idle
        repeat (3) tick();
        check("rst_ram_addr",   32'(ram_addr),   32'd0);
        check("rst_sclk",       32'(vfd_sclk),   32'd0);
        check("rst_sdata",      32'(vfd_sdata),  32'd0);
        check("rst_latch",      32'(vfd_latch),  32'd0);
        check("rst_blank",      32'(vfd_blank),  32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        sysreset_n = 1'b1;
        idle_bad = 0;
        repeat (100) begin
            tick();
            if (vfd_blank !== 1'b1 || vfd_sclk !== 1'b0 || vfd_latch !== 1'b0 ||
                busy !== 1'b0 || ram_addr !== 5'd0) idle_bad++;
        end
        check("idle_quiet_cycles", 32'(idle_bad), 32'd0);

        // Frames 1 and 2; RAM[7] changes 2 -> 8 after frame 1 has latched digit 7.
        base = nlat1;
        c0   = cyc;
        enable = 1'b1;
        for (int i = 0; i < 2000 && (nlat1 - base) < 8; i++) tick();
        check("digit7_latched", 32'((nlat1 - base) >= 8), 32'd1);
        ram[7] = 4'd8;
        for (int i = 0; i < 2000 && fd_cnt < 1; i++) tick();
        check("frame1_done_seen", 32'(fd_cnt), 32'd1);
        check("frame1_done_time", 32'(fd_cyc[0] - c0), 32'd866);
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("status_refetch",   32'(ram_addr),   32'd16);
        tick();
        check("frame_done_1cyc",  32'(frame_done), 32'd0);

        for (int i = 0; i < 3000 && (nlat1 - base) < 37; i++) tick();
        check("frame3_digit4_latched", 32'(nlat1 - base), 32'd37);
        check("f1_digit0",  32'(words[7'(base + 0)]),  32'h00013F);
        check("f1_digit3",  32'(words[7'(base + 3)]),  32'h0008CF);
        check("f1_digit7",  32'(words[7'(base + 7)]),  32'h00805B);
        check("f1_digit10", 32'(words[7'(base + 10)]), 32'h040077);
        check("f1_digit15", 32'(words[7'(base + 15)]), 32'h800071);
        check("f2_digit3",  32'(words[7'(base + 19)]), 32'h0008CF);
        check("f2_digit7",  32'(words[7'(base + 23)]), 32'h00807F);
        check("frame2_len", 32'(fd_cyc[1] - fd_cyc[0]), 32'd865);

        // Drop enable during the SHIFT of frame 3 digit 5.
        for (int i = 0; i < 20 && vfd_sclk !== 1'b1; i++) tick();
        check("digit5_in_shift", 32'(vfd_sclk), 32'd1);
        enable = 1'b0;
        for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
        check("disable_reaches_idle", 32'(busy), 32'd0);
        check("disable_digit5_latched", 32'(nlat1 - base), 32'd38);
        check("disable_digit5_word", 32'(words[7'(base + 37)]), 32'h00206D);
        check("disable_blank", 32'(vfd_blank), 32'd1);
        repeat (20) tick();
        check("disable_no_frame_done", 32'(fd_cnt), 32'd2);
        check("disable_stays_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a shift.
        enable = 1'b1;
        for (int i = 0; i < 20 && vfd_sclk !== 1'b1; i++) tick();
        check("rst2_in_shift", 32'(vfd_sclk), 32'd1);
        sysreset_n = 1'b0;
        #1;
        check("rst2_sclk",     32'(vfd_sclk),   32'd0);
        check("rst2_sdata",    32'(vfd_sdata),  32'd0);
        check("rst2_blank",    32'(vfd_blank),  32'd1);
        check("rst2_latch",    32'(vfd_latch),  32'd0);
        check("rst2_busy",     32'(busy),       32'd0);
        check("rst2_ram_addr", 32'(ram_addr),   32'd0);
        tick();
        sysreset_n = 1'b1;
        tick();
        check("rst2_first_addr",  32'(ram_addr), 32'd16);
        tick();
        check("rst2_second_addr", 32'(ram_addr), 32'd0);
        enable = 1'b0;

        // Serial timing at CLK_DIV=3.
        en3 = 1'b1;
        for (int i = 0; i < 1000 && lat3 < 3; i++) tick();
        check("div3_latches",     32'(lat3 >= 3), 32'd1);
        check("div3_high_phase",  32'(high_bad),  32'd0);
        check("div3_low_phase",   32'(low_bad),   32'd0);
        check("div3_sdata_hold",  32'(sdata_bad), 32'd0);
        check("div3_24_rises",    32'(rise_bad),  32'd0);
        check("div3_digit0_word", 32'(word3),     32'h00013F);
        check("div3_digit_period", 32'(lat_cyc3[1] - lat_cyc3[0]), 32'd150);
        en3 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i4002_vfd_scanner.md
Name: i4002_vfd_scanner

Overview:
- Reads the Working Register (RAM0 register 1) through the second read port of the i4002 register storage: main characters 0..15 plus status character 16.
- Time-multiplexes the digits onto a serial-input VFD grid/segment driver: fetch, 7-segment decode, 24-bit serial shift, latch, then lit dwell.
- Sits between the i4002 RAM0 register 1 instance and the board-level VFD driver pins.

Parameters:
- NUM_DIGITS, 16, digits scanned per frame, 1..16.
- CLK_DIV, 4, sysclk cycles per serial clock half-period, >=1.
- DWELL_CYCLES, 1024, sysclk cycles a digit stays unblanked, >=1.

Ports:
- sysclk  in  1  system clock.
- sysreset_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; level-sensitive.
- ram_addr  out  5  address to the RAM second read port (registered).
- ram_data  in  4  RAM second-port read data; combinational from ram_addr.
- vfd_sclk  out  1  driver serial clock.
- vfd_sdata  out  1  driver serial data, MSB first.
- vfd_latch  out  1  driver latch strobe, one-cycle high pulse.
- vfd_blank  out  1  driver blanking, high = all off.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse after the last digit's dwell.

Behaviour:
- Clock and reset: one clock, sysclk. Reset is asynchronous, active-low, on sysreset_n.
- Reset values: ram_addr=0, vfd_sclk=0, vfd_sdata=0, vfd_latch=0, vfd_blank=1, busy=0, frame_done=0. Internal state: digit=0, dp_pos=0, state=IDLE.
- Asserting reset mid-operation forces these values immediately; no partial shift completes.
- RAM read timing: ram_data is sampled on the sysclk edge that ends a cycle in which ram_addr already holds the wanted address. ram_addr is updated on state entry.
- IDLE: vfd_blank=1. enable=1 -> FETCH_STATUS with ram_addr=16 and digit=0.
- FETCH_STATUS (1 cycle): dp_pos <= ram_data. -> FETCH_DIGIT with ram_addr=digit.
- FETCH_DIGIT (1 cycle):
  - Load the 24-bit shift word:
    - word[23:8] = 16'b1 << digit (grid).
    - word[7] = (digit == dp_pos) (decimal point).
    - word[6:0] = seg{g,f,e,d,c,b,a} of ram_data.
  - Segment codes, hex 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
  - -> SHIFT with bit counter=23.
- SHIFT:
  - Per bit: vfd_sdata = word[bit]. vfd_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - vfd_sdata changes only while vfd_sclk is low.
  - After bit 0's high phase: vfd_sclk=0 -> LATCH.
  - Duration is exactly 48*CLK_DIV cycles. vfd_blank stays 1.
- LATCH (1 cycle): vfd_latch=1, vfd_blank=1. -> DWELL.
- DWELL: vfd_blank=0 for DWELL_CYCLES cycles. Then vfd_blank=1 and:
  - digit < NUM_DIGITS-1: digit++; enable=1 -> FETCH_DIGIT (ram_addr=digit+1); enable=0 -> IDLE.
  - digit == NUM_DIGITS-1: frame_done pulses 1 cycle, digit=0; enable=1 -> FETCH_STATUS (status re-read every frame); enable=0 -> IDLE.
- enable deasserted mid-digit: the current digit completes through DWELL before IDLE, so the display never shows a half-shifted pattern.
- Per-digit period: 1 + 48*CLK_DIV + 1 + DWELL_CYCLES cycles. Per frame, add 1 cycle for FETCH_STATUS.
- RAM contents changing mid-frame: the new value appears on the next fetch of that address; no stale-data guarantee beyond that.
- The block only reads; it never drives a write to the RAM.

Decomposition:
- Shared package i4002_vfd_pkg holds:
  - state encoding constants (IDLE, FETCH_STATUS, FETCH_DIGIT, SHIFT, LATCH, DWELL);
  - WR_STATUS_ADDR = 5'd16;
  - SHIFT_WIDTH = 24;
  - the 16-entry segment table.
- One sub-module: i4002_vfd_segdecode, a combinational nibble-to-7-bit segment map, so it can be reused by the status/LED display.

Test Plan:
- Reset and idle: hold sysreset_n=0, then release with enable=0 for 100 cycles -> blank=1, sclk=0, latch=0, busy=0, ram_addr=0 throughout.
- Single frame: CLK_DIV=1, DWELL_CYCLES=4, RAM[0..15]=0..F, RAM[16]=3, enable=1. Required response:
  - digit 0 shifts 0x00013F;
  - digit 3 shifts 0x0008CF (dp set);
  - digit 15 shifts 0x800071;
  - frame_done pulses once after 1+16*(1+48+1+4)=865 cycles.
- Serial timing: CLK_DIV=3 -> each sclk phase is 3 cycles; sdata is stable across every rising edge; exactly 24 rising edges between consecutive latch pulses.
- Mid-digit disable: drop enable during SHIFT of digit 5 -> digit 5 latches and dwells, then IDLE with blank=1 and no frame_done.
- Async reset mid-SHIFT: assert sysreset_n=0 -> all outputs take reset values before the next sysclk edge; after release with enable=1, the first ram_addr is 16.
- Live update: change RAM[7] from 2 to 8 during frame 1 after digit 7 is fetched -> frame 1 shows 0x5B (2), frame 2 shows 0x7F (8) on digit 7.
